// File: rtl/key_scan_pkg.sv
// key_scan shared types and constants.
// Column drive patterns, FSM state types, sweep-result encoding.
package key_scan_pkg;

    typedef enum logic [1:0] {
        COL0,
        COL1,
        COL2,
        COL3
    } col_state_t;

    typedef enum logic {
        IDLE,
        PRESSED
    } deb_state_t;

    localparam logic [3:0] COL0_DRV = 4'b1110;
    localparam logic [3:0] COL1_DRV = 4'b1101;
    localparam logic [3:0] COL2_DRV = 4'b1011;
    localparam logic [3:0] COL3_DRV = 4'b0111;

    // Sweep result: bit 4 set means no key; above every real code,
    // so a plain less-than picks the lowest code.
    localparam logic [4:0] NONE = 5'b1_0000;

    function automatic logic [3:0] col_drive(input col_state_t s);
        logic [3:0] d;
        d = COL0_DRV;
        unique case (s)
            COL0: d = COL0_DRV;
            COL1: d = COL1_DRV;
            COL2: d = COL2_DRV;
            COL3: d = COL3_DRV;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/key_scan_tick.sv
// Column scan slot timer.
// Pulses scan_tick on the last cycle of each slot.
module key_scan_tick #(
    parameter int cnt_num = 250000
) (
    input  logic clk,
    input  logic rst_n,
    output logic scan_tick
);

    localparam logic [23:0] LAST = 24'(cnt_num - 1);

    logic [23:0] cnt;

    assign scan_tick = (cnt == LAST);

    // Free-running slot counter, wraps after the tick cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (scan_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 24'd1;
        end
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner with sweep-level debounce.
// Emits a one-cycle flag and the key code on each accepted press.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int cnt_num    = 250000,
    parameter int DEB_SWEEPS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       flag,
    output logic [3:0] data
);

    localparam logic [3:0] DEB_MAX = 4'(DEB_SWEEPS);

    col_state_t col_state;
    col_state_t col_next;
    deb_state_t deb_state;
    deb_state_t deb_next;

    logic       scan_tick;
    logic       sweep_end;
    logic [4:0] slot_code;
    logic [4:0] base_min;
    logic [4:0] sweep_res;
    logic [4:0] sweep_min;
    logic [4:0] prev_res;
    logic [3:0] match_cnt;
    logic [3:0] match_nxt;
    logic       flag_nxt;
    logic [3:0] data_nxt;

    key_scan_tick #(
        .cnt_num(cnt_num)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .scan_tick(scan_tick)
    );

    assign col = col_drive(col_state);

    // Column rotation, advancing once per slot.
    always_comb begin
        col_next = col_state;
        if (scan_tick) begin
            unique case (col_state)
                COL0: col_next = COL1;
                COL1: col_next = COL2;
                COL2: col_next = COL3;
                COL3: col_next = COL0;
            endcase
        end
    end

    // Lowest code in this slot, running minimum and match count.
    always_comb begin
        slot_code = NONE;
        for (int r = 3; r >= 0; r--) begin
            if (!row[r]) begin
                slot_code = {1'b0, 2'(r), 2'(col_state)};
            end
        end
        base_min  = (col_state == COL0) ? NONE : sweep_min;
        sweep_res = (slot_code < base_min) ? slot_code : base_min;
        sweep_end = scan_tick && (col_state == COL3);
        if (sweep_res == prev_res) begin
            match_nxt = (match_cnt >= DEB_MAX) ? DEB_MAX
                                               : match_cnt + 4'd1;
        end else begin
            match_nxt = 4'd1;
        end
    end

    // Debounce FSM: press accepted or release confirmed at sweep end.
    always_comb begin
        deb_next = deb_state;
        flag_nxt = 1'b0;
        data_nxt = data;
        if (sweep_end && (match_nxt == DEB_MAX)) begin
            unique case (deb_state)
                IDLE: begin
                    if (sweep_res != NONE) begin
                        deb_next = PRESSED;
                        flag_nxt = 1'b1;
                        data_nxt = sweep_res[3:0];
                    end
                end
                PRESSED: begin
                    if (sweep_res == NONE) begin
                        deb_next = IDLE;
                    end
                end
            endcase
        end
    end

    // State, sweep bookkeeping and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_state <= COL0;
            deb_state <= IDLE;
            sweep_min <= NONE;
            prev_res  <= NONE;
            match_cnt <= 4'd0;
            flag      <= 1'b0;
            data      <= 4'd0;
        end else begin
            col_state <= col_next;
            deb_state <= deb_next;
            flag      <= flag_nxt;
            data      <= data_nxt;
            if (scan_tick) begin
                sweep_min <= sweep_res;
            end
            if (sweep_end) begin
                prev_res  <= sweep_res;
                match_cnt <= match_nxt;
            end
        end
    end

endmodule

// File: tb/tb_key_scan.sv
// Self-checking bench for key_scan (cnt_num=4, DEB_SWEEPS=3).
// Keypad modelled from the pressed-key mask; pulses checked against a key-level model.
module tb_key_scan;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic       flag;
    logic [3:0] data;

    logic [15:0] mask;
    int          cyc;
    int          total;
    int          bad;
    int          p_cyc[$];
    logic [3:0]  p_data[$];
    logic        flag_d;
    int          run;
    int          max_run;

    key_scan #(
        .cnt_num   (4),
        .DEB_SWEEPS(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .row  (row),
        .col  (col),
        .flag (flag),
        .data (data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad: a pressed key k shorts row k/4 to column k%4.
    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (mask[k] && !col[k % 4]) row[k / 4] = 1'b0;
        end
    end

    // Record rising edges of flag and the longest high run.
    initial begin
        flag_d  = 1'b0;
        run     = 0;
        max_run = 0;
    end
    always @(negedge clk) begin
        if (flag === 1'b1) begin
            if (flag_d !== 1'b1) begin
                p_cyc.push_back(cyc);
                p_data.push_back(data);
            end
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        flag_d = flag;
    end

    function automatic int min_code(input logic [15:0] m);
        for (int k = 0; k < 16; k++) if (m[k]) return k;
        return -1;
    endfunction

    task automatic run_press(input logic [15:0] m, input int hold,
                             input int gap, output int np,
                             output logic [3:0] d, output int lat);
        int n0;
        int start;
        @(posedge clk);
        #1;
        n0    = p_cyc.size();
        start = cyc;
        mask  = m;
        repeat (hold) @(posedge clk);
        #1;
        mask = '0;
        repeat (gap) @(posedge clk);
        np  = p_cyc.size() - n0;
        d   = 4'hx;
        lat = -1;
        if (np > 0) begin
            d   = p_data[n0];
            lat = p_cyc[n0] - start;
        end
    endtask

    task automatic test_reset();
        int k;
        int idx;
        logic [3:0] exp_col;
        rst_n = 1'b0;
        mask  = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++;
        if (col !== 4'b1110 || flag !== 1'b0 || data !== 4'd0) begin
            bad++;
            $display("FAIL reset_state col=%b flag=%b data=%0d want 1110/0/0",
                     col, flag, data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = cyc;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            idx     = ((cyc - k) / 4) % 4;
            exp_col = ~(4'b0001 << idx);
            total++;
            if (col !== exp_col) begin
                bad++;
                $display("FAIL col_rotate n=%0d got=%b want=%b", n, col, exp_col);
            end
        end
        total++;
        if (p_cyc.size() !== 0 || data !== 4'd0) begin
            bad++;
            $display("FAIL idle_quiet pulses=%0d data=%0d want 0/0",
                     p_cyc.size(), data);
        end
    endtask

    task automatic test_single();
        int np;
        int lat;
        logic [3:0] d;
        run_press(16'h0002, 500, 500, np, d, lat);
        total++;
        if (np !== 1 || d !== 4'd1) begin
            bad++;
            $display("FAIL single pulses=%0d data=%0d want 1/1", np, d);
        end
        total++;
        if (lat < 0 || lat > 66) begin
            bad++;
            $display("FAIL single_latency got=%0d want<=66", lat);
        end
        total++;
        if (data !== 4'd1) begin
            bad++;
            $display("FAIL data_hold got=%0d want=1", data);
        end
    endtask

    task automatic test_sequence();
        int seq[15] = '{10, 9, 14, 9, 11, 1, 14, 9, 12, 1, 14, 9, 13, 1, 14};
        int np;
        int lat;
        logic [3:0] d;
        foreach (seq[i]) begin
            run_press(16'(1) << seq[i], 500, 500, np, d, lat);
            total++;
            if (np !== 1 || d !== 4'(seq[i]) || lat > 66) begin
                bad++;
                $display("FAIL seq[%0d] pulses=%0d data=%0d lat=%0d want 1/%0d/<=66",
                         i, np, d, lat, seq[i]);
            end
        end
    endtask

    task automatic test_glitch();
        int np;
        int lat;
        logic [3:0] d;
        run_press(16'h0020, 20, 200, np, d, lat);
        total++;
        if (np !== 0) begin
            bad++;
            $display("FAIL glitch pulses=%0d want 0", np);
        end
    endtask

    task automatic test_multi();
        int np;
        int lat;
        logic [3:0] d;
        run_press(16'h0048, 500, 500, np, d, lat);
        total++;
        if (np !== 1 || d !== 4'd3) begin
            bad++;
            $display("FAIL multi pulses=%0d data=%0d want 1/3", np, d);
        end
    endtask

    task automatic test_held_change();
        int n0;
        n0 = p_cyc.size();
        @(posedge clk);
        #1;
        mask = 16'h0004;
        repeat (200) @(posedge clk);
        #1;
        mask = 16'h0100;
        repeat (200) @(posedge clk);
        #1;
        mask = '0;
        repeat (200) @(posedge clk);
        total++;
        if (p_cyc.size() - n0 !== 1 || data !== 4'd2) begin
            bad++;
            $display("FAIL held_change pulses=%0d data=%0d want 1/2",
                     p_cyc.size() - n0, data);
        end
    endtask

    task automatic test_dropout();
        int n0;
        n0 = p_cyc.size();
        @(posedge clk);
        #1;
        mask = 16'h0010;
        repeat (200) @(posedge clk);
        #1;
        mask = '0;
        repeat (20) @(posedge clk);
        #1;
        mask = 16'h0010;
        repeat (200) @(posedge clk);
        #1;
        mask = '0;
        repeat (200) @(posedge clk);
        total++;
        if (p_cyc.size() - n0 !== 1 || data !== 4'd4) begin
            bad++;
            $display("FAIL dropout pulses=%0d data=%0d want 1/4",
                     p_cyc.size() - n0, data);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        int k;
        int lat;
        bit got;
        n0 = p_cyc.size();
        @(posedge clk);
        #1;
        mask = 16'h0080;
        got  = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            if (p_cyc.size() > n0) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL reset_mid_first no pulse got=0 want=1");
        end
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            total++;
            if (flag !== 1'b0 || data !== 4'd0) begin
                bad++;
                $display("FAIL reset_mid_clear flag=%b data=%0d want 0/0",
                         flag, data);
            end
        end
        rst_n = 1'b1;
        k  = cyc;
        n0 = p_cyc.size();
        repeat (150) @(posedge clk);
        lat = (p_cyc.size() > n0) ? p_cyc[n0] - k : -1;
        total++;
        if (p_cyc.size() - n0 !== 1 || data !== 4'd7) begin
            bad++;
            $display("FAIL reset_mid_again pulses=%0d data=%0d want 1/7",
                     p_cyc.size() - n0, data);
        end
        total++;
        if (lat < 48 || lat > 66) begin
            bad++;
            $display("FAIL reset_mid_latency got=%0d want 48..66", lat);
        end
        #1;
        mask = '0;
        repeat (200) @(posedge clk);
    endtask

    task automatic test_random();
        logic [15:0] m;
        logic [3:0]  d;
        bit          long_hold;
        int          hold;
        int          gap;
        int          np;
        int          lat;
        int          exp_np;
        for (int i = 0; i < 16; i++) begin
            m = 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 2) == 0) m |= 16'(1) << $urandom_range(0, 15);
            long_hold = ($urandom_range(0, 3) != 0);
            hold = long_hold ? $urandom_range(120, 300) : $urandom_range(2, 20);
            gap  = $urandom_range(120, 200);
            exp_np = long_hold ? 1 : 0;
            run_press(m, hold, gap, np, d, lat);
            total++;
            if (np !== exp_np) begin
                bad++;
                $display("FAIL rand[%0d] mask=%h hold=%0d pulses=%0d want %0d",
                         i, m, hold, np, exp_np);
            end else if (exp_np == 1) begin
                total++;
                if (d !== 4'(min_code(m)) || lat > 66) begin
                    bad++;
                    $display("FAIL rand_data[%0d] mask=%h data=%0d lat=%0d want %0d/<=66",
                             i, m, d, lat, min_code(m));
                end
            end
        end
    endtask

    task automatic test_pulse_width();
        total++;
        if (max_run !== 1) begin
            bad++;
            $display("FAIL pulse_width max=%0d want 1", max_run);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        mask  = '0;
        test_reset();
        test_single();
        test_sequence();
        test_glitch();
        test_multi();
        test_held_change();
        test_dropout();
        test_reset_mid();
        test_random();
        test_pulse_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
